// File: rtl/uart_rx_fifo_apb.sv
// Receive FIFO between the UART receiver and an APB slave: data/status/ctrl/clear registers and a level irq.
// Optional rx idle-timeout irq source is compiled in when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo_apb #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [8:0]  rx_data,
  input  logic        rx_fe,
  input  logic        rx_be,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          oe;
  logic          irq_en;
  logic [7:0]    threshold;
  logic          timeout_flag;

  logic       access;
  logic [1:0] reg_sel;
  logic       rd_acc;
  logic       empty;
  logic       full;
  logic       pop;
  logic       push;
  logic       overrun;
  logic       clear_wr;
  logic       flush;
  logic       oe_clr;
  logic       ctrl_wr;
  logic       level_ge;
  logic [8:0] thr_eff;
  logic [7:0] level8;
  logic       unused_ok;

  assign access   = psel & penable;
  assign reg_sel  = paddr[3:2];
  assign rd_acc   = access & ~pwrite;
  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign pop      = rd_acc & (reg_sel == 2'd0) & ~empty;
  assign clear_wr = access & pwrite & (reg_sel == 2'd3);
  assign flush    = clear_wr & pwdata[1];
  assign oe_clr   = clear_wr & pwdata[0];
  assign ctrl_wr  = access & pwrite & (reg_sel == 2'd2);

  // A simultaneous pop frees the slot, so a full FIFO still accepts the frame; flush drops it outright.
  assign push    = rx_valid & ~flush & (~full | pop);
  assign overrun = rx_valid & ~flush & full & ~pop;

  assign pready  = 1'b1;
  assign pslverr = access & pwrite & ((reg_sel == 2'd0) | (reg_sel == 2'd1));

  assign thr_eff  = (threshold == 8'd0) ? 9'd1 : {1'b0, threshold};
  assign level_ge = 16'(level) >= 16'(thr_eff);
  // With DEPTH=256 a full FIFO shows level 0 here; the full bit disambiguates.
  assign level8   = 8'(level);

  assign unused_ok = ^{paddr[1:0], pwdata[31:16], pwdata[7:2]};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {rx_be, rx_fe, rx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      oe        <= 1'b0;
      irq_en    <= 1'b0;
      threshold <= 8'd1;
      irq       <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
      if (overrun) begin
        oe <= 1'b1;
      end else if (oe_clr) begin
        oe <= 1'b0;
      end
      if (ctrl_wr) begin
        irq_en    <= pwdata[0];
        threshold <= pwdata[15:8];
      end
      irq <= irq_en & (level_ge | oe | timeout_flag);
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Counts idle cycles with data waiting; saturates so the flag stays asserted until serviced.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (push | pop | flush | empty) begin
        to_cnt <= '0;
      end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
        to_cnt <= to_cnt + TW'(1);
      end
      if (pop | flush) begin
        timeout_flag <= 1'b0;
      end else if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
        timeout_flag <= 1'b1;
      end
    end
  end
`else
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    prdata = '0;
    if (rd_acc) begin
      case (reg_sel)
        2'd0:    prdata = empty ? 32'h8000_0000 : {21'b0, mem[rd_ptr]};
        2'd1:    prdata = {16'b0, level8, 3'b0, timeout_flag, irq, oe, full, empty};
        2'd2:    prdata = {16'b0, threshold, 7'b0, irq_en};
        default: prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_apb.sv
// Scoreboard bench for uart_rx_fifo_apb: frames queued on push, compared on DATA reads.
// Timeout checks are compiled in when UART_RX_TIMEOUT_EN is defined.
module tb_uart_rx_fifo_apb;

  localparam int DEPTH = 16;
  localparam int TIMEOUT_CYCLES = 2000;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [8:0]  rx_data;
  logic        rx_fe;
  logic        rx_be;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;

  int total = 0;
  int bad = 0;
  logic [10:0] exp_q[$];
  logic        model_oe = 1'b0;

  uart_rx_fifo_apb #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_fe(rx_fe), .rx_be(rx_be),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, expv);
    end
  endtask

  function automatic logic [31:0] exp_status(input logic irq_bit, input logic to_bit);
    int n;
    n = exp_q.size();
    return {16'b0, 8'(n), 3'b0, to_bit, irq_bit, model_oe, (n == DEPTH), (n == 0)};
  endfunction

  // One APB transfer; optionally strobes rx_valid during the access cycle.
  task automatic apb_xfer(input bit wr, input logic [3:0] addr, input logic [31:0] wdata,
                          input bit rx, input logic [10:0] frame,
                          output logic [31:0] rd, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    if (rx) begin
      rx_valid = 1'b1;
      {rx_be, rx_fe, rx_data} = frame;
    end
    #3;
    rd = prdata;
    err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [10:0] frame);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    {rx_be, rx_fe, rx_data} = frame;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(frame);
    else model_oe = 1'b1;
  endtask

  task automatic read_reg(input string tag, input logic [3:0] addr, input logic [31:0] expv);
    logic [31:0] rd;
    logic err;
    apb_xfer(1'b0, addr, 32'h0, 1'b0, 11'h0, rd, err);
    checkOutput(tag, rd, expv);
  endtask

  task automatic write_reg(input string tag, input logic [3:0] addr, input logic [31:0] wdata,
                           input logic exp_err);
    logic [31:0] rd;
    logic err;
    apb_xfer(1'b1, addr, wdata, 1'b0, 11'h0, rd, err);
    checkOutput(tag, {31'b0, err}, {31'b0, exp_err});
  endtask

  task automatic read_data(input string tag);
    logic [31:0] rd;
    logic [31:0] expv;
    logic err;
    if (exp_q.size() == 0) expv = 32'h8000_0000;
    else expv = {21'b0, exp_q.pop_front()};
    apb_xfer(1'b0, 4'h0, 32'h0, 1'b0, 11'h0, rd, err);
    checkOutput(tag, rd, expv);
  endtask

  initial begin
    logic [31:0] rd;
    logic err;
    logic [10:0] f;

    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_fe = 1'b0; rx_be = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    checkOutput("idle_prdata", prdata, 32'h0);
    checkOutput("pready", {31'b0, pready}, 32'h1);
    read_reg("reset_status", 4'h4, 32'h0000_0001);
    apb_xfer(1'b0, 4'h0, 32'h0, 1'b0, 11'h0, rd, err);
    checkOutput("empty_data", rd, 32'h8000_0000);
    checkOutput("empty_data_err", {31'b0, err}, 32'h0);

    applyStimulus({1'b0, 1'b1, 9'h1A5});
    apb_xfer(1'b0, 4'h0, 32'h0, 1'b0, 11'h0, rd, err);
    checkOutput("fe_frame", rd, 32'h0000_03A5);
    void'(exp_q.pop_front());
    read_reg("after_pop_status", 4'h4, 32'h0000_0001);

    // Overfill: 17th frame lost and OE raised.
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(11'($urandom));
    read_reg("overrun_status", 4'h4, 32'h0000_1006);
    write_reg("clear_oe_err", 4'hC, 32'h1, 1'b0);
    model_oe = 1'b0;
    read_reg("oe_cleared", 4'h4, 32'h0000_1002);
    for (int i = 0; i < DEPTH; i++) read_data("drain_full");
    read_reg("drained_status", 4'h4, 32'h0000_0001);

    // Threshold interrupt.
    write_reg("ctrl_wr_err", 4'h8, 32'h0000_0401, 1'b0);
    read_reg("ctrl_readback", 4'h8, 32'h0000_0401);
    for (int i = 0; i < 3; i++) applyStimulus(11'($urandom));
    repeat (2) @(posedge clk);
    #1 checkOutput("irq_below_thr", {31'b0, irq}, 32'h0);
    applyStimulus(11'($urandom));
    checkOutput("irq_latency", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    checkOutput("irq_at_thr", {31'b0, irq}, 32'h1);
    read_reg("irq_status", 4'h4, exp_status(1'b1, 1'b0));
    read_data("irq_pop");
    checkOutput("irq_hold", {31'b0, irq}, 32'h1);
    @(posedge clk); #1;
    checkOutput("irq_drop", {31'b0, irq}, 32'h0);
    while (exp_q.size() > 0) read_data("irq_drain");
    write_reg("ctrl_off", 4'h8, 32'h0000_0100, 1'b0);

    // Full FIFO: push and pop in the same cycle never overruns.
    for (int i = 0; i < DEPTH; i++) applyStimulus(11'($urandom));
    f = 11'($urandom);
    apb_xfer(1'b0, 4'h0, 32'h0, 1'b1, f, rd, err);
    checkOutput("pushpop_full_data", rd, {21'b0, exp_q.pop_front()});
    exp_q.push_back(f);
    read_reg("pushpop_full_status", 4'h4, 32'h0000_1002);
    for (int i = 0; i < DEPTH; i++) read_data("pushpop_drain");

    // Empty FIFO: pop ignored, push lands.
    f = 11'($urandom);
    apb_xfer(1'b0, 4'h0, 32'h0, 1'b1, f, rd, err);
    checkOutput("pushpop_empty_data", rd, 32'h8000_0000);
    exp_q.push_back(f);
    read_reg("pushpop_empty_status", 4'h4, exp_status(1'b0, 1'b0));
    read_data("pushpop_empty_pop");

    // Flush with a concurrent frame: frame dropped, no OE.
    for (int i = 0; i < 3; i++) applyStimulus(11'($urandom));
    apb_xfer(1'b1, 4'hC, 32'h2, 1'b1, 11'h7FF, rd, err);
    exp_q.delete();
    read_reg("flush_status", 4'h4, 32'h0000_0001);
    read_data("flush_empty");

    // OE clear racing a new overrun keeps OE.
    for (int i = 0; i < DEPTH; i++) applyStimulus(11'($urandom));
    apb_xfer(1'b1, 4'hC, 32'h1, 1'b1, 11'h123, rd, err);
    model_oe = 1'b1;
    read_reg("oe_race_status", 4'h4, 32'h0000_1006);
    write_reg("flush_clear", 4'hC, 32'h3, 1'b0);
    exp_q.delete();
    model_oe = 1'b0;
    read_reg("flush_clear_status", 4'h4, 32'h0000_0001);

    // Error responses and decode.
    write_reg("data_wr_err", 4'h0, 32'h1, 1'b1);
    write_reg("status_wr_err", 4'h4, 32'hFFFF_FFFF, 1'b1);
    read_reg("status_unchanged", 4'h4, 32'h0000_0001);
    read_reg("clear_reads_zero", 4'hC, 32'h0);
    applyStimulus(11'h155);
    read_reg("low_addr_ignored", 4'h7, exp_status(1'b0, 1'b0));
    read_data("low_addr_pop");

`ifdef UART_RX_TIMEOUT_EN
    write_reg("ctrl_to", 4'h8, 32'h0000_0801, 1'b0);
    applyStimulus(11'h0AA);
    repeat (TIMEOUT_CYCLES - 10) @(posedge clk);
    #1 checkOutput("to_early", {31'b0, irq}, 32'h0);
    repeat (20) @(posedge clk);
    #1 checkOutput("to_irq", {31'b0, irq}, 32'h1);
    read_reg("to_status", 4'h4, exp_status(1'b1, 1'b1));
    read_data("to_pop");
    @(posedge clk); #1;
    checkOutput("to_irq_clear", {31'b0, irq}, 32'h0);
    read_reg("to_status_clear", 4'h4, exp_status(1'b0, 1'b0));
    write_reg("ctrl_to_off", 4'h8, 32'h0000_0100, 1'b0);
`endif

    // Synchronous reset discards queued frames.
    for (int i = 0; i < 3; i++) applyStimulus(11'($urandom));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    model_oe = 1'b0;
    read_reg("midreset_status", 4'h4, 32'h0000_0001);
    read_reg("midreset_ctrl", 4'h8, 32'h0000_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
